tl_host_arb: RTL and testbench



---
 rtl/tinyriscv_pkg.sv | 41 ++++
 rtl/tl_host_arb_if.sv | 38 +++
 rtl/tl_route_fifo.sv | 67 ++++++
 rtl/tl_host_arb.sv | 144 ++++++++++++++
 tb/tb_tl_host_arb.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinyriscv_pkg.sv
// Package: tinyriscv_pkg
// Purpose: shared TileLink-UL types and constants for the core's memory port.
//   - MemAddrBus / MemBus : default address and data widths
//   - TL-UL A and D opcode constants
//   - Host index constants (HostIfu = fetch unit, HostLsu = load/store unit)
//   - tl_a_pkt_t / tl_d_pkt_t : packed A and D channel beats
//   - other_host() : index of the host that is not the given one
package tinyriscv_pkg;

   localparam int MemAddrBus = 32;
   localparam int MemBus     = 32;

   localparam logic [2:0] TlGet           = 3'd4;
   localparam logic [2:0] TlPutFull       = 3'd0;
   localparam logic [2:0] TlPutPartial    = 3'd1;
   localparam logic [2:0] TlAccessAck     = 3'd0;
   localparam logic [2:0] TlAccessAckData = 3'd1;

   localparam logic HostIfu = 1'b0;
   localparam logic HostLsu = 1'b1;

   typedef struct packed {
      logic [2:0]            opcode;
      logic [1:0]            size;
      logic [MemBus/8-1:0]   mask;
      logic [MemAddrBus-1:0] addr;
      logic [MemBus-1:0]     data;
      logic                  source;
   } tl_a_pkt_t;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [MemBus-1:0] data;
      logic              err;
   } tl_d_pkt_t;

   function automatic logic other_host(input logic host);
      return ~host;
   endfunction

endpackage

// File: rtl/tl_host_arb_if.sv
// Interface: tl_host_arb_if
// Purpose: one TileLink-UL link (A request channel + D response channel).
//   master modport: the requesting side (drives A, accepts D)
//   slave  modport: the responding side (accepts A, drives D)
// Signals:
//   a_valid/a_ready, a_opcode(3), a_size(2), a_mask(DW/8), a_addr(AW),
//   a_data(DW), a_source(1), d_valid/d_ready, d_opcode(3), d_data(DW), d_err(1)
interface tl_host_arb_if
   import tinyriscv_pkg::*;
#(
   parameter int AW = MemAddrBus,
   parameter int DW = MemBus
);
   logic            a_valid;
   logic            a_ready;
   logic [2:0]      a_opcode;
   logic [1:0]      a_size;
   logic [DW/8-1:0] a_mask;
   logic [AW-1:0]   a_addr;
   logic [DW-1:0]   a_data;
   logic            a_source;
   logic            d_valid;
   logic            d_ready;
   logic [2:0]      d_opcode;
   logic [DW-1:0]   d_data;
   logic            d_err;

   modport master (
      output a_valid, a_opcode, a_size, a_mask, a_addr, a_data, a_source, d_ready,
      input  a_ready, d_valid, d_opcode, d_data, d_err
   );

   modport slave (
      input  a_valid, a_opcode, a_size, a_mask, a_addr, a_data, a_source, d_ready,
      output a_ready, d_valid, d_opcode, d_data, d_err
   );

endinterface

// File: rtl/tl_route_fifo.sv
// Module: tl_route_fifo
// Purpose: in-order FIFO of 1-bit host indices, one entry per outstanding
//   A request. No bypass: a pop never makes room for a push in the same cycle
//   (the caller sees full for that whole cycle).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push, din    : write din when push and not full
//   pop          : drop the head entry when pop and not empty
//   full, empty  : occupancy flags
//   head         : oldest stored index (valid when !empty)
module tl_route_fifo #(
   parameter int Depth = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW = $clog2(Depth + 1);

   logic [Depth-1:0] mem_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap at Depth, which need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count_reg == CW'(Depth));
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_reg    <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
            wr_ptr_reg          <= next_ptr(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/tl_host_arb.sv
// Module: tl_host_arb
// Purpose: arbitrates two TL-UL hosts (h0 = instruction fetch, h1 = LSU) onto
//   one downstream device link. Each accepted A request records its host index
//   in an in-order route FIFO; D responses are steered to the FIFO head host.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   h0, h1       : host links (slave side of tl_host_arb_if)
//   dev          : device link (master side); dev.a_source = granted host index
// Parameters: AW address width, DW data width, MaxOut max outstanding requests.
// Build option: define TL_ARB_LSU_PRIO_EN for fixed priority to h1 (LSU) on
//   every unlocked contention; otherwise round-robin favouring the host that
//   did not win the last A handshake.
module tl_host_arb
   import tinyriscv_pkg::*;
#(
   parameter int AW     = MemAddrBus,
   parameter int DW     = MemBus,
   parameter int MaxOut = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   tl_host_arb_if.slave  h0,
   tl_host_arb_if.slave  h1,
   tl_host_arb_if.master dev
);

   typedef enum logic {
      ArbOpen,
      ArbLocked
   } arb_state_t;

   arb_state_t arb_state_reg;
   logic       lock_host_reg;
`ifndef TL_ARB_LSU_PRIO_EN
   logic       rr_last_reg;
`endif

   logic            grant;
   logic            grant_valid;
   logic            a_open;
   logic            d_open;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_head;
   logic [AW-1:0]   a_addr_mux;
   logic [DW-1:0]   a_data_mux;
   logic [DW/8-1:0] a_mask_mux;

   // ---------------- grant selection ----------------
   always_comb begin
      grant = HostIfu;
      if (arb_state_reg == ArbLocked) begin
         // A stalled beat must stay on the bus unchanged until accepted.
         grant = lock_host_reg;
      end else begin
`ifdef TL_ARB_LSU_PRIO_EN
         if (h1.a_valid)      grant = HostLsu;
         else if (h0.a_valid) grant = HostIfu;
         else                 grant = HostLsu;
`else
         if (h0.a_valid && h1.a_valid) grant = other_host(rr_last_reg);
         else if (h0.a_valid)          grant = HostIfu;
         else if (h1.a_valid)          grant = HostLsu;
         else                          grant = rr_last_reg;
`endif
      end
   end

   // ---------------- A channel ----------------
   // Reset gates every valid/ready so nothing handshakes while rst_i is high.
   assign a_open      = !rst_i && !fifo_full;
   assign grant_valid = (grant == HostLsu) ? h1.a_valid : h0.a_valid;
   assign a_addr_mux  = (grant == HostLsu) ? h1.a_addr  : h0.a_addr;
   assign a_data_mux  = (grant == HostLsu) ? h1.a_data  : h0.a_data;
   assign a_mask_mux  = (grant == HostLsu) ? h1.a_mask  : h0.a_mask;

   assign dev.a_valid  = grant_valid && a_open;
   assign dev.a_opcode = rst_i ? '0 : ((grant == HostLsu) ? h1.a_opcode : h0.a_opcode);
   assign dev.a_size   = rst_i ? '0 : ((grant == HostLsu) ? h1.a_size : h0.a_size);
   assign dev.a_mask   = rst_i ? '0 : a_mask_mux;
   assign dev.a_addr   = rst_i ? '0 : a_addr_mux;
   assign dev.a_data   = rst_i ? '0 : a_data_mux;
   assign dev.a_source = rst_i ? 1'b0 : grant;

   assign h0.a_ready = a_open && dev.a_ready && (grant == HostIfu);
   assign h1.a_ready = a_open && dev.a_ready && (grant == HostLsu);

   assign push = dev.a_valid && dev.a_ready;

   // ---------------- D channel ----------------
   assign d_open      = !rst_i && !fifo_empty;
   assign h0.d_valid  = dev.d_valid && d_open && (fifo_head == HostIfu);
   assign h1.d_valid  = dev.d_valid && d_open && (fifo_head == HostLsu);
   assign dev.d_ready = d_open && ((fifo_head == HostLsu) ? h1.d_ready : h0.d_ready);
   assign pop         = dev.d_valid && dev.d_ready;

   assign h0.d_opcode = rst_i ? '0 : dev.d_opcode;
   assign h0.d_data   = rst_i ? '0 : dev.d_data;
   assign h0.d_err    = rst_i ? 1'b0 : dev.d_err;
   assign h1.d_opcode = rst_i ? '0 : dev.d_opcode;
   assign h1.d_data   = rst_i ? '0 : dev.d_data;
   assign h1.d_err    = rst_i ? 1'b0 : dev.d_err;

   // ---------------- lock / round-robin state ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         arb_state_reg <= ArbOpen;
         lock_host_reg <= HostIfu;
`ifndef TL_ARB_LSU_PRIO_EN
         rr_last_reg   <= HostLsu;   // so host 0 wins the first contention
`endif
      end else begin
         if (push) begin
            arb_state_reg <= ArbOpen;
`ifndef TL_ARB_LSU_PRIO_EN
            rr_last_reg   <= grant;
`endif
         end else if (dev.a_valid && !dev.a_ready) begin
            arb_state_reg <= ArbLocked;
            lock_host_reg <= grant;
         end
      end
   end

   tl_route_fifo #(
      .Depth(MaxOut)
   ) u_route_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .din   (grant),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // A response with nothing outstanding means the device is out of sync.
   d_without_request : assert property (@(posedge clk_i) disable iff (rst_i)
      !(dev.d_valid && fifo_empty));

endmodule

// File: tb/tb_tl_host_arb.sv
// Testbench: tb_tl_host_arb
// Directed scenarios for tl_host_arb (MaxOut=2): reset, contention order,
// lock on a stalled beat, full route FIFO without bypass, D back-pressure,
// mid-operation reset, and repeated contention. Expected A beats and D
// routing are pushed to queues when stimulus is driven and popped when the
// DUT handshakes. Set TL_ARB_LSU_PRIO_EN to check the fixed-priority build.
module tb_tl_host_arb;
   import tinyriscv_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   tl_host_arb_if #(.AW(32), .DW(32)) h0_if ();
   tl_host_arb_if #(.AW(32), .DW(32)) h1_if ();
   tl_host_arb_if #(.AW(32), .DW(32)) dev_if ();

   tl_host_arb #(
      .AW(32),
      .DW(32),
      .MaxOut(2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .h0    (h0_if),
      .h1    (h1_if),
      .dev   (dev_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   tl_a_pkt_t exp_a_q[$];
   logic      exp_dh_q[$];
   tl_d_pkt_t exp_d_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic tl_a_pkt_t mk_a(input logic host, input logic [2:0] op,
                                      input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] mask);
      tl_a_pkt_t p;
      p.opcode = op;
      p.size   = 2'd2;
      p.mask   = mask;
      p.addr   = addr;
      p.data   = data;
      p.source = host;
      return p;
   endfunction

   task automatic drive_a(input tl_a_pkt_t p);
      if (p.source == HostIfu) begin
         h0_if.a_valid = 1'b1; h0_if.a_opcode = p.opcode; h0_if.a_size = p.size;
         h0_if.a_mask = p.mask; h0_if.a_addr = p.addr; h0_if.a_data = p.data;
      end else begin
         h1_if.a_valid = 1'b1; h1_if.a_opcode = p.opcode; h1_if.a_size = p.size;
         h1_if.a_mask = p.mask; h1_if.a_addr = p.addr; h1_if.a_data = p.data;
      end
   endtask

   task automatic clr_a(input logic host);
      if (host == HostIfu) h0_if.a_valid = 1'b0;
      else                 h1_if.a_valid = 1'b0;
   endtask

   // Drive a request and record its expected beat in one step.
   task automatic req(input tl_a_pkt_t p);
      drive_a(p);
      exp_a_q.push_back(p);
   endtask

   // Expect the next queued beat to handshake this cycle.
   task automatic a_hs(input string tag, input bit keep);
      tl_a_pkt_t e;
      @(negedge clk);
      e = exp_a_q.pop_front();
      $display("A  %s: src=%0d addr=%0h op=%0d", tag, dev_if.a_source, dev_if.a_addr, dev_if.a_opcode);
      chk({tag, ".dev_a_valid"}, dev_if.a_valid, 1);
      chk({tag, ".dev_a_source"}, dev_if.a_source, e.source);
      chk({tag, ".dev_a_addr"}, dev_if.a_addr, e.addr);
      chk({tag, ".dev_a_opcode"}, dev_if.a_opcode, e.opcode);
      chk({tag, ".dev_a_data"}, dev_if.a_data, e.data);
      chk({tag, ".dev_a_mask"}, dev_if.a_mask, e.mask);
      chk({tag, ".h0_a_ready"}, h0_if.a_ready, e.source == HostIfu);
      chk({tag, ".h1_a_ready"}, h1_if.a_ready, e.source == HostLsu);
      exp_dh_q.push_back(e.source);
      @(posedge clk); #1;
      if (!keep) clr_a(e.source);
   endtask

   // Drive one D beat and expect it to reach the host at the route FIFO head.
   task automatic d_hs(input string tag, input logic [2:0] op, input logic [31:0] data,
                       input logic err);
      tl_d_pkt_t d;
      logic      h;
      dev_if.d_valid = 1'b1; dev_if.d_opcode = op; dev_if.d_data = data; dev_if.d_err = err;
      exp_d_q.push_back('{opcode: op, data: data, err: err});
      @(negedge clk);
      h = exp_dh_q.pop_front();
      d = exp_d_q.pop_front();
      $display("D  %s: h0_v=%0d h1_v=%0d data=%0h", tag, h0_if.d_valid, h1_if.d_valid, dev_if.d_data);
      chk({tag, ".h0_d_valid"}, h0_if.d_valid, h == HostIfu);
      chk({tag, ".h1_d_valid"}, h1_if.d_valid, h == HostLsu);
      chk({tag, ".dev_d_ready"}, dev_if.d_ready, 1);
      chk({tag, ".d_data"}, (h == HostLsu) ? h1_if.d_data : h0_if.d_data, d.data);
      chk({tag, ".d_opcode"}, (h == HostLsu) ? h1_if.d_opcode : h0_if.d_opcode, d.opcode);
      chk({tag, ".d_err"}, (h == HostLsu) ? h1_if.d_err : h0_if.d_err, d.err);
      @(posedge clk); #1;
      dev_if.d_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      h0_if.a_valid = 0; h0_if.a_opcode = TlGet; h0_if.a_size = 2; h0_if.a_mask = 4'hF;
      h0_if.a_addr = 32'h123; h0_if.a_data = 0; h0_if.a_source = 0; h0_if.d_ready = 1;
      h1_if.a_valid = 0; h1_if.a_opcode = TlGet; h1_if.a_size = 2; h1_if.a_mask = 4'hF;
      h1_if.a_addr = 0; h1_if.a_data = 0; h1_if.a_source = 1; h1_if.d_ready = 1;
      dev_if.a_ready = 1; dev_if.d_valid = 0; dev_if.d_opcode = 0; dev_if.d_data = 0;
      dev_if.d_err = 0;

      // ---- reset: outputs gated even with a host requesting and device ready
      rst = 1'b1;
      h0_if.a_valid = 1'b1;
      @(negedge clk);
      $display("RST: dev_a_valid=%0d h0_a_ready=%0d", dev_if.a_valid, h0_if.a_ready);
      chk("rst.dev_a_valid", dev_if.a_valid, 0);
      chk("rst.h0_a_ready", h0_if.a_ready, 0);
      chk("rst.h1_a_ready", h1_if.a_ready, 0);
      chk("rst.dev_d_ready", dev_if.d_ready, 0);
      chk("rst.h0_d_valid", h0_if.d_valid, 0);
      chk("rst.h1_d_valid", h1_if.d_valid, 0);
      chk("rst.dev_a_addr", dev_if.a_addr, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      h0_if.a_valid = 1'b0;
      @(negedge clk);
      chk("idle.dev_a_valid", dev_if.a_valid, 0);
      @(posedge clk); #1;

      // ---- 1: simultaneous Gets, first contention
      drive_a(mk_a(HostIfu, TlGet, 32'h100, 0, 4'hF));
      drive_a(mk_a(HostLsu, TlGet, 32'h200, 0, 4'hF));
`ifdef TL_ARB_LSU_PRIO_EN
      exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'h200, 0, 4'hF));
      exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'h100, 0, 4'hF));
`else
      exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'h100, 0, 4'hF));
      exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'h200, 0, 4'hF));
`endif
      a_hs("t1.first", 0);
      a_hs("t1.second", 0);
      d_hs("t1.d_first", TlAccessAckData, 32'hAAAA, 0);
      d_hs("t1.d_second", TlAccessAckData, 32'hBBBB, 0);

      // ---- 2: lock holds a stalled h0 beat against a valid h1
      req(mk_a(HostIfu, TlGet, 32'h300, 0, 4'hF));
      a_hs("t2.pre", 0);
      d_hs("t2.pre_d", TlAccessAckData, 32'h3333, 0);
      dev_if.a_ready = 1'b0;
      drive_a(mk_a(HostIfu, TlGet, 32'h400, 0, 4'hF));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         $display("T2 stall %0d: src=%0d addr=%0h", i, dev_if.a_source, dev_if.a_addr);
         chk("t2.stall_valid", dev_if.a_valid, 1);
         chk("t2.stall_source", dev_if.a_source, HostIfu);
         chk("t2.stall_addr", dev_if.a_addr, 32'h400);
         chk("t2.stall_h0_ready", h0_if.a_ready, 0);
         chk("t2.stall_h1_ready", h1_if.a_ready, 0);
         @(posedge clk); #1;
         if (i == 0) drive_a(mk_a(HostLsu, TlGet, 32'h500, 0, 4'hF));
      end
      dev_if.a_ready = 1'b1;
      exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'h400, 0, 4'hF));
      exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'h500, 0, 4'hF));
      a_hs("t2.h0", 0);
      a_hs("t2.h1", 0);
      d_hs("t2.d_h0", TlAccessAckData, 32'h4444, 0);
      d_hs("t2.d_h1", TlAccessAckData, 32'h5555, 0);

      // ---- 3: full route FIFO, same-cycle pop does not admit a push
      req(mk_a(HostIfu, TlGet, 32'h600, 0, 4'hF));
      a_hs("t3.fill0", 0);
      req(mk_a(HostLsu, TlGet, 32'h700, 0, 4'hF));
      a_hs("t3.fill1", 0);
      drive_a(mk_a(HostIfu, TlGet, 32'h800, 0, 4'hF));
      @(negedge clk);
      $display("T3 full: dev_a_valid=%0d h0_a_ready=%0d", dev_if.a_valid, h0_if.a_ready);
      chk("t3.full_dev_a_valid", dev_if.a_valid, 0);
      chk("t3.full_h0_a_ready", h0_if.a_ready, 0);
      chk("t3.full_h1_a_ready", h1_if.a_ready, 0);
      @(posedge clk); #1;
      dev_if.d_valid = 1'b1; dev_if.d_opcode = TlAccessAck; dev_if.d_data = 32'h11;
      dev_if.d_err = 1'b1;
      @(negedge clk);
      $display("T3 pop: dev_a_valid=%0d h0_d_valid=%0d", dev_if.a_valid, h0_if.d_valid);
      chk("t3.pop_dev_a_valid", dev_if.a_valid, 0);
      chk("t3.pop_h0_a_ready", h0_if.a_ready, 0);
      chk("t3.pop_h0_d_valid", h0_if.d_valid, 1);
      chk("t3.pop_h1_d_valid", h1_if.d_valid, 0);
      chk("t3.pop_dev_d_ready", dev_if.d_ready, 1);
      chk("t3.pop_h0_d_err", h0_if.d_err, 1);
      void'(exp_dh_q.pop_front());
      @(posedge clk); #1;
      dev_if.d_valid = 1'b0; dev_if.d_err = 1'b0;
      exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'h800, 0, 4'hF));
      a_hs("t3.freed", 0);
      d_hs("t3.d_h1", TlAccessAckData, 32'h7777, 0);
      d_hs("t3.d_h0", TlAccessAckData, 32'h8888, 0);

      // ---- 4: h1 PutFull, h1 holds off the response for two cycles
      req(mk_a(HostLsu, TlPutFull, 32'h900, 32'hDEADBEEF, 4'hF));
      a_hs("t4.put", 0);
      h1_if.d_ready = 1'b0;
      dev_if.d_valid = 1'b1; dev_if.d_opcode = TlAccessAck; dev_if.d_data = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         $display("T4 hold %0d: h1_d_valid=%0d dev_d_ready=%0d", i, h1_if.d_valid, dev_if.d_ready);
         chk("t4.hold_h1_d_valid", h1_if.d_valid, 1);
         chk("t4.hold_h0_d_valid", h0_if.d_valid, 0);
         chk("t4.hold_dev_d_ready", dev_if.d_ready, 0);
         @(posedge clk); #1;
      end
      h1_if.d_ready = 1'b1;
      d_hs("t4.ack", TlAccessAck, 0, 0);
      @(negedge clk);
      chk("t4.empty_dev_d_ready", dev_if.d_ready, 0);
      @(posedge clk); #1;

      // ---- 5: reset with two requests outstanding
      req(mk_a(HostLsu, TlGet, 32'hA00, 0, 4'hF));
      a_hs("t5.out0", 0);
      req(mk_a(HostIfu, TlGet, 32'hA10, 0, 4'hF));
      a_hs("t5.out1", 0);
      drive_a(mk_a(HostIfu, TlGet, 32'hB00, 0, 4'hF));
      drive_a(mk_a(HostLsu, TlGet, 32'hB10, 0, 4'hF));
      dev_if.d_valid = 1'b1; dev_if.d_data = 32'hA0A0;
      #2;
      rst = 1'b1;
      #1;
      $display("T5 rst: dev_a_valid=%0d dev_d_ready=%0d", dev_if.a_valid, dev_if.d_ready);
      chk("t5.rst_dev_a_valid", dev_if.a_valid, 0);
      chk("t5.rst_h0_a_ready", h0_if.a_ready, 0);
      chk("t5.rst_h1_a_ready", h1_if.a_ready, 0);
      chk("t5.rst_dev_d_ready", dev_if.d_ready, 0);
      chk("t5.rst_h0_d_valid", h0_if.d_valid, 0);
      chk("t5.rst_h1_d_valid", h1_if.d_valid, 0);
      exp_dh_q.delete();
      @(posedge clk); #1;
      dev_if.d_valid = 1'b0;
      rst = 1'b0;
`ifdef TL_ARB_LSU_PRIO_EN
      exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'hB10, 0, 4'hF));
      exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'hB00, 0, 4'hF));
`else
      exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'hB00, 0, 4'hF));
      exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'hB10, 0, 4'hF));
`endif
      a_hs("t5.after0", 0);
      a_hs("t5.after1", 0);
      d_hs("t5.d0", TlAccessAckData, 32'hB0B0, 0);
      d_hs("t5.d1", TlAccessAckData, 32'hB1B1, 0);

      // ---- 6: both hosts continuously valid
      for (int r = 0; r < 2; r++) begin
         drive_a(mk_a(HostIfu, TlGet, 32'hC00, 0, 4'hF));
         drive_a(mk_a(HostLsu, TlGet, 32'hC10, 0, 4'hF));
`ifdef TL_ARB_LSU_PRIO_EN
         exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'hC10, 0, 4'hF));
         exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'hC10, 0, 4'hF));
`else
         exp_a_q.push_back(mk_a(HostIfu, TlGet, 32'hC00, 0, 4'hF));
         exp_a_q.push_back(mk_a(HostLsu, TlGet, 32'hC10, 0, 4'hF));
`endif
         a_hs("t6.first", 1);
         a_hs("t6.second", 1);
         clr_a(HostIfu);
         clr_a(HostLsu);
         d_hs("t6.d0", TlAccessAckData, 32'hC0 + 32'(r), 0);
         d_hs("t6.d1", TlAccessAckData, 32'hC8 + 32'(r), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
